reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/rf_pkg.sv | 11 +
 rtl/wr_req_fifo.sv | 55 +++++
 rtl/reg_write_arbiter.sv | 92 +++++++++
 tb/tb_reg_write_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Register-file write types shared by the writeback arbiter and its B-side buffer.
package rf_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } rf_wr_req_t;
endpackage

// File: rtl/wr_req_fifo.sv
// Purpose: small circular buffer of register write requests, exposing per-entry addresses.
// Latency: an entry pushed this cycle is visible at the head from the next cycle.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module wr_req_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  rf_wr_req_t                           push_req,
    input  logic                                 pop,
    output rf_wr_req_t                           head,
    output logic [$clog2(DEPTH+1)-1:0]           count,
    output logic [DEPTH-1:0]                     entry_vld,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     entry_addr
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rf_wr_req_t       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    assign head = mem[rd_ptr];

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_req;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [PTR_W-1:0] age;
        assign age           = PTR_W'(i) - rd_ptr;
        assign entry_vld[i]  = CNT_W'(age) < count;
        assign entry_addr[i] = mem[i].addr;
    end
endmodule

// File: rtl/reg_write_arbiter.sv
// Purpose: merges core (A) and buffered multi-cycle (B) writebacks onto one register-file write port.
// Latency: A writes 1 cycle after handshake, B writes at least 2 cycles after handshake.
// Backpressure: a_ready drops only when a starved B entry is forced ahead; b_ready drops when the buffer is full.
module reg_write_arbiter
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [REG_ADDR_W-1:0] a_addr,
    input  logic [XLEN-1:0]       a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_addr,
    input  logic [XLEN-1:0]       b_data,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [XLEN-1:0]       wr_data,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic                  starve
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    rf_wr_req_t                                head;
    logic [CNT_W-1:0]                          fifo_count;
    logic [FIFO_DEPTH-1:0]                     entry_vld;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0]     entry_addr;
    logic [3:0]                                starve_cnt;
    logic                                      fifo_nonempty;
    logic                                      push;
    logic                                      pop;
    logic                                      grant_a;

    assign fifo_nonempty = fifo_count != '0;
    assign starve        = fifo_nonempty && (starve_cnt == 4'(STARVE_LIMIT));
    assign a_ready       = !starve;
    assign b_ready       = fifo_count < CNT_W'(FIFO_DEPTH);
    assign push          = b_valid && b_ready;
    assign pop           = starve || (!a_valid && fifo_nonempty);
    assign grant_a       = a_valid && !starve;

    wr_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_req   ('{addr: b_addr, data: b_data}),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count),
        .entry_vld  (entry_vld),
        .entry_addr (entry_addr)
    );

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_vld[i]) pending_mask[entry_addr[i]] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

    // Writes to x0 still consume their grant but never reach the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            if (!fifo_nonempty || pop)
                starve_cnt <= '0;
            else if (starve_cnt != 4'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 4'd1;

            if (grant_a) begin
                wr_en   <= a_addr != '0;
                wr_addr <= a_addr;
                wr_data <= a_data;
            end else if (pop) begin
                wr_en   <= head.addr != '0;
                wr_addr <= head.addr;
                wr_data <= head.data;
            end else begin
                wr_en <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a queue-based reference model checked every cycle.
module tb_reg_write_arbiter;
    import rf_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr, wr_addr;
    logic [31:0] a_data, b_data, wr_data;
    logic        wr_en, starve;
    logic [31:0] pending_mask;

    int checks = 0;
    int errors = 0;

    reg_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pending_mask(pending_mask), .starve(starve)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending B writes, a wait counter and the last write.
    rf_wr_req_t  q[$];
    int          sc      = 0;
    logic        m_wr_en = 1'b0;
    logic [4:0]  m_addr  = '0;
    logic [31:0] m_data  = '0;

    function automatic logic m_starve();
        return (q.size() > 0) && (sc == LIMIT);
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m = '0;
        foreach (q[i]) if (q[i].addr != 0) m[q[i].addr] = 1'b1;
        return m;
    endfunction

    initial begin
        int         n;
        logic       got, popped;
        rf_wr_req_t g, e;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                sc = 0; m_wr_en = 1'b0; m_addr = '0; m_data = '0;
            end else begin
                n = q.size();
                got = 1'b0; popped = 1'b0;
                if (m_starve() || (!a_valid && n > 0)) begin
                    g = q.pop_front(); got = 1'b1; popped = 1'b1;
                end else if (a_valid) begin
                    g.addr = a_addr; g.data = a_data; got = 1'b1;
                end
                if (b_valid && n < DEPTH) begin
                    e.addr = b_addr; e.data = b_data; q.push_back(e);
                end
                if (n == 0 || popped) sc = 0;
                else if (sc < LIMIT)  sc = sc + 1;
                if (got) begin
                    m_wr_en = g.addr != 0; m_addr = g.addr; m_data = g.data;
                end else begin
                    m_wr_en = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("model a_ready", 32'(a_ready), 32'(!m_starve()));
            chk("model b_ready", 32'(b_ready), 32'(q.size() < DEPTH));
            chk("model starve", 32'(starve), 32'(m_starve()));
            chk("model pending_mask", pending_mask, m_mask());
            chk("model wr_en", 32'(wr_en), 32'(m_wr_en));
            chk("model wr_addr", 32'(wr_addr), 32'(m_addr));
            chk("model wr_data", wr_data, m_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        #1;
        chk("reset wr_en", 32'(wr_en), 32'd0);
        chk("reset wr_addr", 32'(wr_addr), 32'd0);
        chk("reset wr_data", wr_data, 32'd0);
        chk("reset mask", pending_mask, 32'd0);
        chk("reset a_ready", 32'(a_ready), 32'd1);
        chk("reset b_ready", 32'(b_ready), 32'd1);
        chk("reset starve", 32'(starve), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        cyc();

        // A only
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h0000000C;
        chk("a_only a_ready", 32'(a_ready), 32'd1);
        cyc();
        a_valid = 1'b0;
        chk("a_only wr_en", 32'(wr_en), 32'd1);
        chk("a_only wr_addr", 32'(wr_addr), 32'd3);
        chk("a_only wr_data", wr_data, 32'h0000000C);
        cyc();
        chk("idle wr_en", 32'(wr_en), 32'd0);
        chk("idle wr_addr hold", 32'(wr_addr), 32'd3);

        // B only
        b_valid = 1'b1; b_addr = 5'd5; b_data = 32'hFFFFFFF7;
        cyc();
        b_valid = 1'b0;
        chk("b_only mask", pending_mask, 32'h00000020);
        chk("b_only wr_en early", 32'(wr_en), 32'd0);
        cyc();
        chk("b_only wr_en", 32'(wr_en), 32'd1);
        chk("b_only wr_addr", 32'(wr_addr), 32'd5);
        chk("b_only wr_data", wr_data, 32'hFFFFFFF7);
        chk("b_only mask clear", pending_mask, 32'd0);

        // Starvation with A held busy
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h100;
        b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h88;
        cyc();
        b_valid = 1'b0;
        chk("starve initial", 32'(starve), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            a_data = 32'h100 + 32'(k);
            cyc();
            chk("starve ramp", 32'(starve), (k == 4) ? 32'd1 : 32'd0);
        end
        chk("starve a_ready", 32'(a_ready), 32'd0);
        chk("starve last A", wr_data, 32'h104);
        cyc();
        chk("starve b wr_addr", 32'(wr_addr), 32'd8);
        chk("starve b wr_data", wr_data, 32'h88);
        chk("starve released", 32'(a_ready), 32'd1);
        a_data = 32'h200;
        cyc();
        chk("starve a resumes", wr_data, 32'h200);
        a_valid = 1'b0;
        cyc();

        // Full buffer with A busy
        a_valid = 1'b1; a_addr = 5'd2; a_data = 32'h300;
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h9;
        cyc();
        b_addr = 5'd10; b_data = 32'hA;
        chk("full b_ready one", 32'(b_ready), 32'd1);
        cyc();
        b_addr = 5'd11; b_data = 32'hB;
        chk("full b_ready zero", 32'(b_ready), 32'd0);
        chk("full mask", pending_mask, 32'h00000600);
        repeat (3) cyc();
        chk("full still blocked", 32'(b_ready), 32'd0);
        chk("full starve", 32'(starve), 32'd1);
        cyc();
        chk("full first pop", 32'(wr_addr), 32'd9);
        chk("full b_ready back", 32'(b_ready), 32'd1);
        cyc();
        a_valid = 1'b0; b_valid = 1'b0;
        chk("full third pushed", pending_mask, 32'h00000C00);
        cyc();
        chk("full order 2", 32'(wr_addr), 32'd10);
        cyc();
        chk("full order 3", 32'(wr_addr), 32'd11);
        chk("full order 3 data", wr_data, 32'hB);
        cyc();

        // Writes to x0
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hDEAD;
        cyc();
        a_valid = 1'b0;
        chk("x0 a wr_en", 32'(wr_en), 32'd0);
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h1;
        cyc();
        b_valid = 1'b0;
        chk("x0 mask bit0", pending_mask, 32'd0);
        cyc();
        chk("x0 b wr_en", 32'(wr_en), 32'd0);
        chk("x0 b popped", 32'(b_ready), 32'd1);
        cyc();

        // Reset mid-run with two buffered entries
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h44;
        b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h6;
        cyc();
        b_addr = 5'd7; b_data = 32'h7;
        cyc();
        b_valid = 1'b0;
        chk("pre-reset mask", pending_mask, 32'h000000C0);
        chk("pre-reset wr_en", 32'(wr_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        a_valid = 1'b0;
        chk("async reset mask", pending_mask, 32'd0);
        chk("async reset wr_en", 32'(wr_en), 32'd0);
        chk("async reset b_ready", 32'(b_ready), 32'd1);
        chk("async reset wr_addr", 32'(wr_addr), 32'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("post-reset no write", 32'(wr_en), 32'd0);
            chk("post-reset mask", pending_mask, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
